load_unit_ctrl: RTL and testbench
=================================

# load_unit_ctrl

Multi-cycle load controller between the MIPS datapath and the data-memory port. It accepts one load command (LB/LBU/LH/LHU/LW), issues a word-aligned request/acknowledge transaction to memory, then selects the addressed byte or halfword and sign- or zero-extends it to 32 bits. The result goes to the register-file write-back mux. Misaligned addresses, illegal opcodes and memory timeouts finish with an error flag and no register data.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent waiting for `mem_ack` before the transaction is aborted; legal range is 1 to 255.
- `clk`, input, 1 bit: the single clock; all logic is rising-edge triggered.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: command strobe; sampled only in IDLE.
- `op`, input, 3 bits: load type. 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; every other code is illegal.
- `addr`, input, 32 bits: byte address, sampled together with `start`.
- `busy`, output, 1 bit: high whenever the state is not IDLE.
- `done`, output, 1 bit: one-cycle completion pulse.
- `err`, output, 1 bit: valid while `done` is high; holds its value until the next accepted `start`.
- `rdata`, output, 32 bits: extended load result; holds until the next accepted `start`.
- `mem_req`, output, 1 bit: memory request; held high until acknowledged.
- `mem_addr`, output, 32 bits: word address, equal to `{addr[31:2], 2'b00}`.
- `mem_ack`, input, 1 bit: memory acknowledge; may be asserted in the same cycle `mem_req` rises.
- `mem_rdata`, input, 32 bits: read word, valid in the cycle `mem_ack` is high.

## Operation
- **Commands.** `op` and `addr` are registered on the clock edge where `start` is high and the state is IDLE. `start` is ignored in every other state.
- **Byte order.** Memory is big-endian.
  - Byte offset 0 is `[31:24]`, 1 is `[23:16]`, 2 is `[15:8]`, 3 is `[7:0]`.
  - Halfword offset 0 is `[31:16]`, offset 2 is `[15:0]`.
- **Extension.**
  - LB and LH replicate the MSB of the selected field into the upper bits.
  - LBU and LHU zero-fill the upper bits.
  - LW passes the word through unchanged.
- **Error checks.** A check is made at accept time. The command goes to ERR, with no memory access, if any of these holds:
  - LH or LHU with `addr[0]=1`.
  - LW with `addr[1:0]≠00`.
  - An illegal `op` code.
- **States.**
  - IDLE: accept a command and go to REQ, or to ERR if the check fails.
  - REQ: `mem_req=1`. On `mem_ack`, capture and extend `mem_rdata` into `rdata`, set `err=0`, and go to DONE. If the wait counter reaches TIMEOUT_CYCLES first, go to ERR.
  - ERR: load `rdata=0` and `err=1`, then go to DONE.
  - DONE: `done=1` for one cycle, then go to IDLE.
- **Wait counter.** An 8-bit counter is cleared on entry to REQ and increments each REQ cycle without `mem_ack`.
- **Ack/timeout collision.** If `mem_ack` is high in the cycle the counter hits the limit, the ack wins and the load completes normally.
- **Reset.** Reset at any time, including mid-transaction, forces:
  - state to IDLE;
  - `mem_req` to 0 immediately (asynchronous);
  - `busy`, `done` and `err` to 0;
  - `rdata` and `mem_addr` to 0;
  - the wait counter to 0.
- **After reset.** A late `mem_ack` arriving after reset is ignored.

## Timing
- `start` sampled at edge T. Then `busy` and `mem_req` are high in cycle T+1.
- `mem_ack` sampled at edge T+k. Then `done`, `rdata` and `err` are valid in cycle T+k+1.
- Minimum latency is 2 cycles, with the ack arriving in the first REQ cycle.
- Error path latency is 2 cycles: ERR, then DONE.
- Timeout: `done` with `err=1` arrives TIMEOUT_CYCLES+2 cycles after `start`.
- `mem_req` is low in DONE. The earliest next accepted `start` is the cycle after `done`.
- Outputs are registered. `mem_addr` is stable for the whole time `mem_req` is high.

## Structure
- The shared package `mips_pkg` holds:
  - the `op` encodings as localparams `LD_LB`, `LD_LH`, `LD_LW`, `LD_LBU`, `LD_LHU`;
  - the state encoding IDLE, REQ, ERR, DONE.
- One combinational sub-module, `load_extender`, performs field selection and extension. Its inputs are `op`, the offset `addr[1:0]` and `word`; its output is the extended result.
- The top level contains the FSM, the wait counter and the output registers.

## Test plan
- LB at `addr=0x1001`, memory word `0x12F45678`, ack in the first REQ cycle. Required: `rdata=0xFFFFFFF4`, `err=0`, `done` 2 cycles after `start`, `mem_addr=0x1000`.
- LBU at the same address with the same data. Required: `rdata=0x000000F4`. LHU at `addr=0x2002` with word `0xAAAA8001`. Required: `rdata=0x00008001`. LH at the same address. Required: `rdata=0xFFFF8001`.
- LW at `addr=0x3002`. Required: `mem_req` never rises, `done` at T+2, `err=1`, `rdata=0`. Also apply `op=011`. Required: the same error response.
- LW with `mem_ack` delayed by 5 cycles. Required: `mem_req` held for 6 cycles, `mem_addr` stable throughout, and a `start` pulse during `busy` is ignored.
- Run with TIMEOUT_CYCLES=4 and no ack. Required: `done` with `err=1` at T+6. Repeat with the ack arriving on the limit cycle. Required: a normal completion with `err=0`.
- Assert `rst_n` low while in REQ. Required: `mem_req=0` with no clock edge. Then deassert reset and send an ack. Required: no `done` is produced.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg: load opcode encodings, load-controller states and command check. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } ld_state_t;

  // Legal opcode with a naturally aligned address for its access size.
  function automatic logic ld_cmd_legal(input logic [2:0] op, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (op)
      LD_LB, LD_LBU: ok = 1'b1;
      LD_LH, LD_LHU: ok = ~off[0];
      LD_LW:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extender.sv
// ----------------------------------------------------------------------------
// load_extender: big-endian byte/halfword select with sign or zero extension. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_extender
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_f;
  logic [15:0] half_f;

  always_comb begin
    byte_f = 8'h00;
    half_f = 16'h0000;
    result = 32'h0000_0000;

    // Offset 0 is the most significant byte of the word.
    case (offset)
      2'd0:    byte_f = word[31:24];
      2'd1:    byte_f = word[23:16];
      2'd2:    byte_f = word[15:8];
      default: byte_f = word[7:0];
    endcase

    half_f = offset[1] ? word[15:0] : word[31:16];

    case (op)
      LD_LB:   result = {{24{byte_f[7]}}, byte_f};
      LD_LBU:  result = {24'h000000, byte_f};
      LD_LH:   result = {{16{half_f[15]}}, half_f};
      LD_LHU:  result = {16'h0000, half_f};
      LD_LW:   result = word;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_unit_ctrl.sv
// ----------------------------------------------------------------------------
// load_unit_ctrl: one-command load sequencer with req/ack memory handshake and timeout. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_unit_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Last REQ cycle index that may still be acknowledged before aborting.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  ld_state_t   state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  wait_cnt;
  logic [31:0] ext_word;

  load_extender u_ext (
    .op     (op_q),
    .offset (off_q),
    .word   (mem_rdata),
    .result (ext_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0000_0000;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0000_0000;
      wait_cnt <= 8'h00;
      op_q     <= 3'b000;
      off_q    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op;
            off_q    <= addr[1:0];
            mem_addr <= {addr[31:2], 2'b00};
            busy     <= 1'b1;
            wait_cnt <= 8'h00;
            if (ld_cmd_legal(op, addr[1:0])) begin
              mem_req <= 1'b1;
              state   <= REQ;
            end else begin
              state   <= ERR;
            end
          end
        end

        REQ: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (mem_ack) begin
            rdata   <= ext_word;
            err     <= 1'b0;
            done    <= 1'b1;
            mem_req <= 1'b0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'h01;
            if (wait_cnt == TO_LAST) begin
              mem_req <= 1'b0;
              state   <= ERR;
            end
          end
        end

        ERR: begin
          rdata <= 32'h0000_0000;
          err   <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_unit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_load_unit_ctrl: directed load vectors against two controllers (default and short timeout). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_load_unit_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        start_x;
  logic        ack_x;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] mem_rdata;

  logic        busy_a, done_a, err_a, mem_req_a;
  logic [31:0] rdata_a, mem_addr_a;
  logic        busy_b, done_b, err_b, mem_req_b;
  logic [31:0] rdata_b, mem_addr_b;

  wire start_a = start_x & ~sel;
  wire start_b = start_x & sel;
  wire ack_a   = ack_x & ~sel;
  wire ack_b   = ack_x & sel;

  wire        cur_busy  = sel ? busy_b     : busy_a;
  wire        cur_done  = sel ? done_b     : done_a;
  wire        cur_err   = sel ? err_b      : err_a;
  wire        cur_req   = sel ? mem_req_b  : mem_req_a;
  wire [31:0] cur_rdata = sel ? rdata_b    : rdata_a;
  wire [31:0] cur_maddr = sel ? mem_addr_b : mem_addr_a;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_unit_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .op        (op),
    .addr      (addr),
    .busy      (busy_a),
    .done      (done_a),
    .err       (err_a),
    .rdata     (rdata_a),
    .mem_req   (mem_req_a),
    .mem_addr  (mem_addr_a),
    .mem_ack   (ack_a),
    .mem_rdata (mem_rdata)
  );

  load_unit_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .op        (op),
    .addr      (addr),
    .busy      (busy_b),
    .done      (done_b),
    .err       (err_b),
    .rdata     (rdata_b),
    .mem_req   (mem_req_b),
    .mem_addr  (mem_addr_b),
    .mem_ack   (ack_b),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. ack_at is the 1-based REQ cycle that gets the ack (0 = never).
  task automatic run_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                          input int ack_at, input bit poke,
                          output int lat, output int reqs, output bit stable);
    logic [31:0] exp_addr;
    exp_addr  = {a[31:2], 2'b00};
    op        = o;
    addr      = a;
    mem_rdata = w;
    start_x   = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    lat     = 1;
    reqs    = 0;
    stable  = 1'b1;
    while (cur_done !== 1'b1 && lat < 300) begin
      if (cur_req === 1'b1) begin
        reqs++;
        if (cur_maddr !== exp_addr) stable = 1'b0;
      end
      ack_x = (cur_req === 1'b1) && (reqs == ack_at);
      if (poke && cur_req === 1'b1 && reqs == 2) begin
        start_x = 1'b1;
        op      = LD_LB;
        addr    = a + 32'h100;
      end
      @(negedge clk);
      lat++;
      ack_x   = 1'b0;
      start_x = 1'b0;
    end
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chk(tag, {30'd0, cur_busy, cur_done}, 32'd0);
  endtask

  int lat, reqs;
  bit stable;

  initial begin
    rst_n = 1'b0; sel = 1'b0; start_x = 1'b0; ack_x = 1'b0;
    op = 3'b000; addr = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, busy_a},    32'd0);
    chk("rst_done",  {31'd0, done_a},    32'd0);
    chk("rst_err",   {31'd0, err_a},     32'd0);
    chk("rst_req",   {31'd0, mem_req_a}, 32'd0);
    chk("rst_rdata", rdata_a,            32'd0);
    chk("rst_maddr", mem_addr_a,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LB, ack in first REQ cycle
    run_load(LD_LB, 32'h0000_1001, 32'h12F4_5678, 1, 1'b0, lat, reqs, stable);
    chk("lb_done",   {31'd0, cur_done}, 32'd1);
    chk("lb_rdata",  cur_rdata, 32'hFFFF_FFF4);
    chk("lb_err",    {31'd0, cur_err}, 32'd0);
    chk("lb_lat",    lat, 32'd2);
    chk("lb_reqs",   reqs, 32'd1);
    chk("lb_maddr",  {31'd0, stable}, 32'd1);
    post_idle("lb_idle");

    run_load(LD_LBU, 32'h0000_1001, 32'h12F4_5678, 1, 1'b0, lat, reqs, stable);
    chk("lbu_rdata", cur_rdata, 32'h0000_00F4);
    post_idle("lbu_idle");

    run_load(LD_LHU, 32'h0000_2002, 32'hAAAA_8001, 1, 1'b0, lat, reqs, stable);
    chk("lhu_rdata", cur_rdata, 32'h0000_8001);
    post_idle("lhu_idle");

    run_load(LD_LH, 32'h0000_2002, 32'hAAAA_8001, 1, 1'b0, lat, reqs, stable);
    chk("lh_rdata",  cur_rdata, 32'hFFFF_8001);
    chk("lh_err",    {31'd0, cur_err}, 32'd0);
    post_idle("lh_idle");

    run_load(LD_LH, 32'h0000_2000, 32'h7ABC_0001, 1, 1'b0, lat, reqs, stable);
    chk("lh0_rdata", cur_rdata, 32'h0000_7ABC);
    post_idle("lh0_idle");

    run_load(LD_LB, 32'h0000_1003, 32'h1234_5680, 1, 1'b0, lat, reqs, stable);
    chk("lb3_rdata", cur_rdata, 32'hFFFF_FF80);
    post_idle("lb3_idle");

    // Misaligned LW: no memory access
    run_load(LD_LW, 32'h0000_3002, 32'hDEAD_BEEF, 1, 1'b0, lat, reqs, stable);
    chk("mis_done",  {31'd0, cur_done}, 32'd1);
    chk("mis_err",   {31'd0, cur_err}, 32'd1);
    chk("mis_rdata", cur_rdata, 32'd0);
    chk("mis_lat",   lat, 32'd2);
    chk("mis_reqs",  reqs, 32'd0);
    post_idle("mis_idle");

    run_load(LD_LH, 32'h0000_2001, 32'hDEAD_BEEF, 1, 1'b0, lat, reqs, stable);
    chk("mish_err",  {31'd0, cur_err}, 32'd1);
    chk("mish_reqs", reqs, 32'd0);
    post_idle("mish_idle");

    run_load(3'b011, 32'h0000_3000, 32'hDEAD_BEEF, 1, 1'b0, lat, reqs, stable);
    chk("ill_err",   {31'd0, cur_err}, 32'd1);
    chk("ill_rdata", cur_rdata, 32'd0);
    chk("ill_lat",   lat, 32'd2);
    chk("ill_reqs",  reqs, 32'd0);
    post_idle("ill_idle");

    // LW, ack delayed 5 cycles, stray start while busy
    run_load(LD_LW, 32'h0000_4004, 32'hCAFE_F00D, 6, 1'b1, lat, reqs, stable);
    chk("lwd_rdata", cur_rdata, 32'hCAFE_F00D);
    chk("lwd_err",   {31'd0, cur_err}, 32'd0);
    chk("lwd_reqs",  reqs, 32'd6);
    chk("lwd_lat",   lat, 32'd7);
    chk("lwd_maddr", {31'd0, stable}, 32'd1);
    post_idle("lwd_idle");
    chk("lwd_maddr_held", cur_maddr, 32'h0000_4004);

    // Short-timeout controller
    sel = 1'b1;
    run_load(LD_LW, 32'h0000_5000, 32'h1111_2222, 0, 1'b0, lat, reqs, stable);
    chk("to_done",   {31'd0, cur_done}, 32'd1);
    chk("to_err",    {31'd0, cur_err}, 32'd1);
    chk("to_rdata",  cur_rdata, 32'd0);
    chk("to_lat",    lat, 32'd6);
    chk("to_reqs",   reqs, 32'd4);
    post_idle("to_idle");

    run_load(LD_LW, 32'h0000_5000, 32'h1111_2222, 4, 1'b0, lat, reqs, stable);
    chk("tol_err",   {31'd0, cur_err}, 32'd0);
    chk("tol_rdata", cur_rdata, 32'h1111_2222);
    chk("tol_lat",   lat, 32'd5);
    post_idle("tol_idle");

    // Reset in REQ, then a late ack
    sel = 1'b0;
    op = LD_LW; addr = 32'h0000_6000; mem_rdata = 32'h5555_AAAA; start_x = 1'b1;
    @(negedge clk);
    start_x = 1'b0;
    chk("rr_req_pre", {31'd0, mem_req_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_async", {31'd0, mem_req_a}, 32'd0);
    chk("rr_busy",      {31'd0, busy_a},    32'd0);
    chk("rr_maddr",     mem_addr_a,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_x = 1'b1;
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        ack_x = 1'b0;
        if (done_a === 1'b1 || busy_a === 1'b1 || mem_req_a === 1'b1) saw = 1'b1;
      end
      chk("rr_no_done", {31'd0, saw}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
